// File: rtl/regbuf_pkg.sv
// regbuf_pkg: shared widths, entry/state types and the forwarding scan step used by regfile_write_buffer.
package regbuf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    // Callers feed entries oldest first, so a later hit overrides an earlier one.
    function automatic logic [DATA_W:0] youngest_match(
        input logic [DATA_W:0] acc,
        input logic            vld,
        input entry_t          e,
        input logic [ADDR_W-1:0] key
    );
        return (vld && key != '0 && e.addr == key) ? {1'b1, e.data} : acc;
    endfunction

endpackage

// File: rtl/regbuf_fifo.sv
// regbuf_fifo: circular entry store with count/full/empty and an oldest-first view of all entries.
module regbuf_fifo
    import regbuf_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  entry_t                 i_entry,
    output entry_t                 o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output entry_t [DEPTH-1:0]     o_entries,
    output logic [DEPTH-1:0]       o_valid
);

    localparam int PW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= i_pop ? r_head + 1'b1 : r_head;
            r_tail  <= i_push ? r_tail + 1'b1 : r_tail;
            r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge clock)
        if (i_push) r_mem[r_tail] <= i_entry;

    // Rotate so index 0 is the head; the scan then runs oldest to youngest.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            o_entries[k] = r_mem[r_head + PW'(k)];
            o_valid[k]   = (PW+1)'(k) < r_count;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_full  = r_count == (PW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;

endmodule

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: queues writeback writes and replays each as a one-cycle RegWrite pulse, forwarding pending values.
// Define REGBUF_BYPASS_EN to also forward the write being accepted in the current cycle.
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = regbuf_pkg::ADDR_W,
    parameter int DATA_W = regbuf_pkg::DATA_W
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [ADDR_W-1:0]      wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   rf_RegWrite,
    output logic [ADDR_W-1:0]      rf_writeRegister,
    output logic [DATA_W-1:0]      rf_writeData,
    input  logic [ADDR_W-1:0]      lookup_reg1,
    input  logic [ADDR_W-1:0]      lookup_reg2,
    output logic                   fwd_hit1,
    output logic [DATA_W-1:0]      fwd_data1,
    output logic                   fwd_hit2,
    output logic [DATA_W-1:0]      fwd_data2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle
);

    import regbuf_pkg::*;

    state_t             r_state;
    entry_t             w_in;
    entry_t             w_head;
    entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]   w_valid;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic [DATA_W:0]    w_fwd1;
    logic [DATA_W:0]    w_fwd2;

    // $zero writes complete the handshake but are dropped here.
    assign w_in     = {wb_reg, wb_data};
    assign wb_ready = !w_full;
    assign w_accept = wb_valid && wb_ready;
    assign w_push   = w_accept && wb_reg != '0;
    assign idle     = w_empty && r_state == IDLE;

    regbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (r_state == WRITE),
        .i_entry   (w_in),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            rf_RegWrite      <= 1'b0;
            rf_writeRegister <= '0;
            rf_writeData     <= '0;
        end else begin
            case (r_state)
                IDLE: if (!w_empty) begin
                    rf_RegWrite      <= 1'b1;
                    rf_writeRegister <= w_head.addr;
                    rf_writeData     <= w_head.data;
                    r_state          <= WRITE;
                end
                WRITE: begin
                    rf_RegWrite <= 1'b0;
                    r_state     <= GAP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd1 = youngest_match(w_fwd1, w_valid[k], w_entries[k], lookup_reg1);
            w_fwd2 = youngest_match(w_fwd2, w_valid[k], w_entries[k], lookup_reg2);
        end
`ifdef REGBUF_BYPASS_EN
        w_fwd1 = youngest_match(w_fwd1, w_accept, w_in, lookup_reg1);
        w_fwd2 = youngest_match(w_fwd2, w_accept, w_in, lookup_reg2);
`endif
    end

    assign fwd_hit1  = w_fwd1[DATA_W];
    assign fwd_data1 = w_fwd1[DATA_W-1:0];
    assign fwd_hit2  = w_fwd2[DATA_W];
    assign fwd_data2 = w_fwd2[DATA_W-1:0];

endmodule
